tx_frame_feeder: RTL and testbench



---
 rtl/tx_pkg.sv | 17 +
 rtl/tx_frame_feeder_if.sv | 12 +
 rtl/tx_bank_ram.sv | 33 +++
 rtl/tx_frame_feeder.sv | 152 +++++++++++++++
 tb/tb_tx_frame_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the RGMII transmit path: frame geometry, clock
// rate, feeder timing defaults and the launch FSM state encoding.
package tx_pkg;

   localparam int FRAME_BYTES   = 1024;         // payload bytes per frame (shared with the transmitter)
   localparam int RGMII_CLK_HZ  = 125_000_000;  // transmit clock frequency
   localparam int IFG_CYCLES    = 12;           // default inter-frame gap in clock cycles
   localparam int START_TIMEOUT = 16;           // default launch-to-txctl timeout in clock cycles

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      SENDING    = 2'd2,
      GAP        = 2'd3
   } feed_state_t;

endpackage

// File: rtl/tx_frame_feeder_if.sv
// Byte-stream input of the frame feeder.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// the source holds in_data/in_valid stable until that edge, and in_ready
// may change only after a rising edge.
interface tx_frame_feeder_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input  in_ready);
   modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/tx_bank_ram.sv
// Two-bank payload store: one write port, one synchronous read port with a
// single cycle of read latency. The read register clears on reset so the
// transmitter sees zero before any read completes.
module tx_bank_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(2 * DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [2*DEPTH];
   logic [7:0] rdata_q;

   // Write port: one byte per accepted transfer.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Read port: address registered into data every edge, no enable.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rdata_q <= '0;
      else          rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/tx_frame_feeder.sv
// Ping-pong payload feeder for the RGMII transmitter. Fills two banks from a
// byte stream, launches one frame per full bank by toggling idx, holds the
// bank until its frame has left the wire, and enforces an inter-frame gap.
module tx_frame_feeder
   import tx_pkg::*;
#(
   parameter int DEPTH    = FRAME_BYTES,
   parameter int IFG_CYC  = IFG_CYCLES,
   parameter int START_TO = START_TIMEOUT
) (
   input  logic                     clk125,
   input  logic                     rst_n,
   tx_frame_feeder_if.slave         in_if,
   input  logic                     txctl,
   input  logic [$clog2(DEPTH):0]   txad,
   output logic [7:0]               data1,
   output logic                     idx,
   output logic [15:0]              frames_sent,
   output logic                     start_err,
   output feed_state_t              dbg_state_o
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_MAX = (IFG_CYC > START_TO) ? IFG_CYC : START_TO;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   feed_state_t      state_q, state_d;
   logic             idx_q, idx_d;
   logic             wr_bank_q, wr_bank_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0]       full_q, full_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      frames_q, frames_d;
   logic             start_err_q, start_err_d;
   logic             bank_release;
   logic             in_ready;
   logic             accept;
   logic             last_byte;

   // A bank accepts bytes only while it is not holding a pending frame.
   assign in_ready       = !full_q[wr_bank_q];
   assign in_if.in_ready = in_ready;
   assign accept         = in_if.in_valid && in_ready;
   assign last_byte      = accept && (wr_ptr_q == PTR_W'(DEPTH - 1));

   // Write pointer and bank selection for the incoming stream.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      wr_bank_d = wr_bank_q;
      if (accept) begin
         if (last_byte) begin
            wr_ptr_d  = '0;
            wr_bank_d = ~wr_bank_q;
         end else begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
         end
      end
   end

   // Full flags: set by the final byte of a bank, cleared when its frame ends.
   // Set and clear never target the same bank because a full bank is not written.
   always_comb begin
      full_d = full_q;
      if (last_byte)    full_d[wr_bank_q] = 1'b1;
      if (bank_release) full_d[idx_q]     = 1'b0;
   end

   // Launch FSM: next state, shared timeout/gap counter, and status outputs.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      frames_d     = frames_q;
      start_err_d  = start_err_q;
      bank_release = 1'b0;
      case (state_q)
         IDLE: begin
            if (full_q[~idx_q]) begin
               idx_d   = ~idx_q;
               cnt_d   = '0;
               state_d = WAIT_START;
            end
         end
         WAIT_START: begin
            if (txctl) begin
               state_d = SENDING;
            end else if (cnt_q == CNT_W'(START_TO - 1)) begin
               start_err_d  = 1'b1;
               bank_release = 1'b1;
               cnt_d        = '0;
               state_d      = GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SENDING: begin
            if (!txctl) begin
               bank_release = 1'b1;
               frames_d     = frames_q + 16'd1;
               cnt_d        = '0;
               state_d      = GAP;
            end
         end
         GAP: begin
            // Any activity on the wire restarts the idle count.
            if (txctl)                                 cnt_d   = '0;
            else if (cnt_q == CNT_W'(IFG_CYC - 1))     state_d = IDLE;
            else                                       cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; the first fill goes to bank 1 so the first launch toggles idx 0->1.
   always_ff @(posedge clk125 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= 1'b0;
         wr_bank_q   <= 1'b1;
         wr_ptr_q    <= '0;
         full_q      <= 2'b00;
         cnt_q       <= '0;
         frames_q    <= 16'd0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wr_bank_q   <= wr_bank_d;
         wr_ptr_q    <= wr_ptr_d;
         full_q      <= full_d;
         cnt_q       <= cnt_d;
         frames_q    <= frames_d;
         start_err_q <= start_err_d;
      end
   end

   tx_bank_ram #(.DEPTH(DEPTH), .AW(PTR_W + 1)) u_ram (
      .clk_i   (clk125),
      .rst_n_i (rst_n),
      .we_i    (accept),
      .waddr_i ({wr_bank_q, wr_ptr_q}),
      .wdata_i (in_if.in_data),
      .raddr_i (txad),
      .rdata_o (data1)
   );

   assign idx         = idx_q;
   assign frames_sent = frames_q;
   assign start_err   = start_err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tx_frame_feeder.sv
// Bench for tx_frame_feeder: byte-stream driver, transmitter model that reads
// a frame back through txad/data1, and a scoreboard of expected bytes and
// expected launch banks.
module tb_tx_frame_feeder;
   import tx_pkg::*;

   localparam int DEPTH = FRAME_BYTES;

   logic        clk125;
   logic        rst_n;
   logic        txctl;
   logic [10:0] txad;
   logic [7:0]  data1;
   logic        idx;
   logic [15:0] frames_sent;
   logic        start_err;
   feed_state_t dbg_state;

   tx_frame_feeder_if s_if ();

   tx_frame_feeder dut (
      .clk125      (clk125),
      .rst_n       (rst_n),
      .in_if       (s_if),
      .txctl       (txctl),
      .txad        (txad),
      .data1       (data1),
      .idx         (idx),
      .frames_sent (frames_sent),
      .start_err   (start_err),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk125 = 1'b0;
   always #4 clk125 = ~clk125;

   int cyc = 0;
   always @(posedge clk125) cyc <= cyc + 1;

   int idx_changes = 0;
   always @(idx) idx_changes++;

   // scoreboard state
   logic [7:0] exp_q[$];
   logic       launch_q[$];
   int         m_fill;
   logic       m_wr_bank;
   int         acc_cnt = 0;
   int         stall_cnt = 0;
   int         fall_cyc = 0;
   int         gl_fall_cyc = 0;
   int         errors = 0;
   int         checks = 0;

   task automatic apply_reset();
      s_if.in_valid = 1'b0;
      s_if.in_data  = 8'h00;
      txctl         = 1'b0;
      txad          = 11'd0;
      @(negedge clk125);
      #2 rst_n = 1'b0;
      exp_q.delete();
      launch_q.delete();
      m_fill    = 0;
      m_wr_bank = 1'b1;
      repeat (3) @(negedge clk125);
      rst_n = 1'b1;
      @(negedge clk125);
   endtask

   // Driver: offers n bytes (value i*mul+add), pushing each accepted one to the scoreboard.
   task automatic send_bytes(input int n, input int mul, input int add);
      int i = 0;
      int stall = 0;
      logic [7:0] v;
      while (i < n) begin
         v = 8'(i * mul + add);
         @(negedge clk125);
         s_if.in_data  = v;
         s_if.in_valid = 1'b1;
         if (s_if.in_ready === 1'b1) begin
            exp_q.push_back(v);
            acc_cnt++;
            i++;
            m_fill++;
            if (m_fill == DEPTH) begin
               launch_q.push_back(m_wr_bank);
               m_wr_bank = ~m_wr_bank;
               m_fill    = 0;
            end
         end else begin
            stall++;
            stall_cnt++;
            if (stall > 6000) begin
               checks++; errors++;
               $display("FAIL send_stall accepted=%0d required=%0d", i, n);
               i = n;
            end
         end
      end
      @(negedge clk125);
      s_if.in_valid = 1'b0;
   endtask

   // Transmitter model: waits for an idx toggle, checks the launched bank,
   // holds txctl for 'hold' cycles while reading the bank, optional gap glitch.
   task automatic xmit_frame(input int hold, input bit glitch, output int t_cyc);
      logic       prev;
      logic       bank;
      logic       exp_b;
      logic [7:0] exp_d;
      logic [7:0] first_got;
      logic [7:0] first_exp;
      int         first_k;
      int         bad;
      int         w;
      prev = idx; w = 0; bad = 0; first_k = -1;
      first_got = 8'h00; first_exp = 8'h00;
      t_cyc = cyc;
      while (idx === prev && w < 3000) begin
         @(negedge clk125);
         w++;
      end
      if (idx === prev) begin
         checks++; errors++;
         $display("FAIL launch_wait idx=%0b required_toggle_from=%0b", idx, prev);
         return;
      end
      t_cyc = cyc;
      bank  = idx;
      checks++;
      if (launch_q.size() == 0) begin
         errors++;
         $display("FAIL launch_order bank=%0d required=none", bank);
      end else begin
         exp_b = launch_q.pop_front();
         if (bank !== exp_b) begin
            errors++;
            $display("FAIL launch_order bank=%0d required=%0d", bank, exp_b);
         end
      end
      @(negedge clk125);
      txctl = 1'b1;
      txad  = {bank, 10'd0};
      for (int k = 1; k <= hold; k++) begin
         @(negedge clk125);
         if (k <= DEPTH) begin
            if (exp_q.size() == 0) begin
               if (bad == 0) first_k = k - 1;
               bad++;
            end else begin
               exp_d = exp_q.pop_front();
               if (data1 !== exp_d) begin
                  if (bad == 0) begin
                     first_k = k - 1; first_got = data1; first_exp = exp_d;
                  end
                  bad++;
               end
            end
         end
         if (k < DEPTH) txad = {bank, 10'(k)};
      end
      txctl    = 1'b0;
      fall_cyc = cyc;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL frame_data bank=%0d bad_bytes=%0d first_off=%0d got=%02h required=%02h",
                  bank, bad, first_k, first_got, first_exp);
      end
      if (glitch) begin
         repeat (5) @(negedge clk125);
         txctl = 1'b1;
         @(negedge clk125);
         txctl = 1'b0;
         gl_fall_cyc = cyc;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (idx !== 1'b0)          begin errors++; $display("FAIL reset_idx got=%0b required=0", idx); end
      checks++; if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b required=1", s_if.in_ready); end
      checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames got=%0d required=0", frames_sent); end
      checks++; if (start_err !== 1'b0)    begin errors++; $display("FAIL reset_start_err got=%0b required=0", start_err); end
      checks++; if (data1 !== 8'h00)       begin errors++; $display("FAIL reset_data1 got=%02h required=00", data1); end
      checks++; if (dbg_state !== IDLE)    begin errors++; $display("FAIL reset_state got=%0d required=%0d", dbg_state, IDLE); end
   endtask

   task automatic test_single_frame();
      int base;
      int t;
      apply_reset();
      base = idx_changes;
      fork
         send_bytes(DEPTH, 1, 0);
         xmit_frame(1030, 1'b0, t);
      join
      repeat (40) @(negedge clk125);
      checks++; if (idx_changes - base != 1) begin errors++; $display("FAIL single_toggles got=%0d required=1", idx_changes - base); end
      checks++; if (idx !== 1'b1)            begin errors++; $display("FAIL single_idx got=%0b required=1", idx); end
      checks++; if (frames_sent !== 16'd1)   begin errors++; $display("FAIL single_frames got=%0d required=1", frames_sent); end
   endtask

   task automatic test_back_to_back();
      int base;
      int drop_acc;
      int rise_cyc;
      int f1;
      int t;
      int w;
      apply_reset();
      base = acc_cnt; drop_acc = -1; rise_cyc = -1; f1 = 0;
      fork
         send_bytes(3 * DEPTH, 1, 0);
         begin
            xmit_frame(1052, 1'b0, t);
            f1 = fall_cyc;
            xmit_frame(1052, 1'b0, t);
            xmit_frame(1052, 1'b0, t);
         end
         begin
            w = 0;
            while (s_if.in_ready === 1'b1 && w < 4000) begin @(negedge clk125); w++; end
            if (s_if.in_ready !== 1'b1) begin
               drop_acc = acc_cnt - base;
               w = 0;
               while (s_if.in_ready !== 1'b1 && w < 4000) begin @(negedge clk125); w++; end
               if (s_if.in_ready === 1'b1) rise_cyc = cyc;
            end
         end
      join
      repeat (3) @(negedge clk125);
      checks++; if (drop_acc != 2 * DEPTH) begin errors++; $display("FAIL b2b_ready_drop after_bytes=%0d required=%0d", drop_acc, 2 * DEPTH); end
      checks++; if (rise_cyc != f1 + 1)    begin errors++; $display("FAIL b2b_ready_rise cycle=%0d required=%0d", rise_cyc, f1 + 1); end
      checks++; if (frames_sent !== 16'd3) begin errors++; $display("FAIL b2b_frames got=%0d required=3", frames_sent); end
   endtask

   task automatic test_gap();
      int f1;
      int f2;
      int gl;
      int t2;
      int t3;
      int t;
      apply_reset();
      f1 = 0; f2 = 0; gl = 0; t2 = 0; t3 = 0;
      fork
         send_bytes(3 * DEPTH, 5, 1);
         begin
            xmit_frame(1030, 1'b0, t);
            f1 = fall_cyc;
            xmit_frame(1030, 1'b1, t2);
            f2 = fall_cyc;
            gl = gl_fall_cyc;
            xmit_frame(1030, 1'b0, t3);
         end
      join
      repeat (3) @(negedge clk125);
      checks++;
      if (t2 - f1 < IFG_CYCLES || t2 - f1 > IFG_CYCLES + 2) begin
         errors++; $display("FAIL gap_min toggle_after=%0d required_range=%0d..%0d", t2 - f1, IFG_CYCLES, IFG_CYCLES + 2);
      end
      checks++;
      if (t3 - gl < IFG_CYCLES || t3 - gl > IFG_CYCLES + 2) begin
         errors++; $display("FAIL gap_glitch toggle_after=%0d required_range=%0d..%0d", t3 - gl, IFG_CYCLES, IFG_CYCLES + 2);
      end
      checks++;
      if (t3 - f2 <= IFG_CYCLES + 2) begin
         errors++; $display("FAIL gap_restart toggle_after_fall=%0d required_above=%0d", t3 - f2, IFG_CYCLES + 2);
      end
      checks++; if (frames_sent !== 16'd3) begin errors++; $display("FAIL gap_frames got=%0d required=3", frames_sent); end
   endtask

   task automatic test_start_timeout();
      int t_cyc;
      int s_cyc;
      int w;
      int stall_base;
      apply_reset();
      t_cyc = -1; s_cyc = -1;
      fork
         send_bytes(DEPTH, 1, 0);
         begin
            w = 0;
            while (idx === 1'b0 && w < 3000) begin @(negedge clk125); w++; end
            if (idx === 1'b1) begin
               t_cyc = cyc;
               w = 0;
               while (start_err !== 1'b1 && w < 100) begin @(negedge clk125); w++; end
               if (start_err === 1'b1) s_cyc = cyc;
            end
         end
      join
      checks++;
      if (t_cyc < 0 || s_cyc < 0 || s_cyc - t_cyc != START_TIMEOUT) begin
         errors++; $display("FAIL start_timeout delay=%0d required=%0d", s_cyc - t_cyc, START_TIMEOUT);
      end
      checks++; if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL timeout_in_ready got=%0b required=1", s_if.in_ready); end
      stall_base = stall_cnt;
      send_bytes(2 * DEPTH, 3, 1);
      checks++; if (stall_cnt != stall_base) begin errors++; $display("FAIL timeout_release stalls=%0d required=0", stall_cnt - stall_base); end
      checks++; if (start_err !== 1'b1)      begin errors++; $display("FAIL start_err_sticky got=%0b required=1", start_err); end
      apply_reset();
      checks++; if (start_err !== 1'b0)      begin errors++; $display("FAIL start_err_clear got=%0b required=0", start_err); end
   endtask

   task automatic test_reset_midfill();
      int t;
      apply_reset();
      fork
         send_bytes(DEPTH, 1, 0);
         xmit_frame(1030, 1'b0, t);
      join
      send_bytes(500, 1, 0);
      checks++; if (idx !== 1'b1) begin errors++; $display("FAIL midfill_pre_idx got=%0b required=1", idx); end
      @(negedge clk125);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (idx !== 1'b0)           begin errors++; $display("FAIL midfill_idx got=%0b required=0", idx); end
      checks++; if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL midfill_in_ready got=%0b required=1", s_if.in_ready); end
      checks++; if (frames_sent !== 16'd0)  begin errors++; $display("FAIL midfill_frames got=%0d required=0", frames_sent); end
      exp_q.delete();
      launch_q.delete();
      m_fill    = 0;
      m_wr_bank = 1'b1;
      repeat (2) @(negedge clk125);
      rst_n = 1'b1;
      @(negedge clk125);
      fork
         send_bytes(DEPTH, 7, 3);
         xmit_frame(1030, 1'b0, t);
      join
      repeat (3) @(negedge clk125);
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL midfill_refill_frames got=%0d required=1", frames_sent); end
   endtask

   initial begin
      rst_n         = 1'b0;
      txctl         = 1'b0;
      txad          = 11'd0;
      s_if.in_valid = 1'b0;
      s_if.in_data  = 8'h00;
      m_fill        = 0;
      m_wr_bank     = 1'b1;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gap();
      test_start_timeout();
      test_reset_midfill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
